// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem req/ack handshake and a
// 2-entry instruction queue whose head is presented to decode.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2,
  output logic [2:0]  opcode
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]  state_reg;
  logic [15:0] pc_reg;
  logic [15:0] req_addr_reg;
  logic [1:0]  count_reg;
  logic [15:0] q_pc_reg    [2];
  logic [15:0] q_instr_reg [2];

  logic        pop;
  logic        push;
  logic        space;
  logic [1:0]  wr_idx;
  logic [1:0]  count_next;
  logic [15:0] redirect_target;

  assign redirect_target = redirect_pc & 16'hFFFE;

  assign pop        = if_valid & ~stall & ~redirect;
  assign push       = (state_reg == REQ) & imem_ack & ~redirect;
  // Slot the pushed word lands in, after this cycle's pop has shifted the queue.
  assign wr_idx     = count_reg - {1'b0, pop};
  assign count_next = wr_idx + {1'b0, push};
  assign space      = (count_next < 2'd2);

  assign imem_req    = (state_reg != IDLE);
  assign imem_addr   = req_addr_reg;
  assign if_valid    = (count_reg != 2'd0);
  assign if_instr    = if_valid ? q_instr_reg[0] : 16'h0000;
  assign if_pc       = if_valid ? q_pc_reg[0] : 16'h0000;
  assign if_pc_plus2 = if_valid ? (q_pc_reg[0] + 16'd2) : 16'h0000;
  assign opcode      = if_instr[15:13];

  // Queue storage needs no reset: the outputs are gated by count_reg.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push && (wr_idx == 2'(i))) begin
        q_pc_reg[i]    <= req_addr_reg;
        q_instr_reg[i] <= imem_rdata;
      end else if (pop && (i == 0)) begin
        q_pc_reg[i]    <= q_pc_reg[1];
        q_instr_reg[i] <= q_instr_reg[1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC & 16'hFFFE;
      req_addr_reg <= 16'h0000;
      count_reg    <= 2'd0;
    end else begin
      count_reg <= redirect ? 2'd0 : count_next;
      case (state_reg)
        IDLE: begin
          if (redirect) begin
            pc_reg <= redirect_target;
          end else if (space) begin
            req_addr_reg <= pc_reg;
            pc_reg       <= pc_reg + 16'd2;
            state_reg    <= REQ;
          end
        end
        REQ: begin
          if (redirect) begin
            pc_reg    <= redirect_target;
            state_reg <= imem_ack ? IDLE : DROP;
          end else if (imem_ack) begin
            if (space) begin
              req_addr_reg <= pc_reg;
              pc_reg       <= pc_reg + 16'd2;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        DROP: begin
          // The in-flight word belongs to the old path; wait it out and discard.
          if (redirect) pc_reg <= redirect_target;
          if (imem_ack) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 16-bit MIPS core. It holds the PC, issues requests to instruction memory over a req/ack handshake, and buffers returned words in a 2-entry queue. The head entry is presented to decode; its opcode field drives the control unit directly. Decode can stall the stage, and the branch/jump resolution logic can redirect it and flush it.

## Interface
- `RESET_PC`, 16'h0000: PC loaded on reset. Bit 0 is ignored.
- `clk` input 1: clock. All state updates on the rising edge.
- `reset` input 1: reset, synchronous, active-high.
- `imem_req` output 1: request outstanding to instruction memory.
- `imem_addr` output 16: byte address of the outstanding request. Bit 0 is always 0.
- `imem_ack` input 1: one-cycle pulse per request. It may arrive in the first cycle `imem_req` is high.
- `imem_rdata` input 16: instruction word. Valid only when `imem_ack`=1.
- `stall` input 1: decode cannot accept the head entry this cycle.
- `redirect` input 1: taken branch or jump. Flushes the stage.
- `redirect_pc` input 16: new fetch PC. Bit 0 is forced to 0.
- `if_valid` output 1: head entry is valid.
- `if_instr` output 16: head instruction. 0 when `if_valid`=0.
- `if_pc` output 16: address of the head instruction. 0 when `if_valid`=0.
- `if_pc_plus2` output 16: `if_pc`+2, modulo 2^16. 0 when `if_valid`=0.
- `opcode` output 3: `if_instr[15:13]`. Feeds the control unit.

## Operation
- **State**
  - `pc`: next address to issue.
  - `req_addr`: address of the in-flight request.
  - `count`: queue occupancy, 0..2.
  - FSM state: one of IDLE, REQ, DROP.
  - `imem_req` = (state != IDLE). `imem_addr` = `req_addr`.
- **Pop**: pop = `if_valid` & !`stall` & !`redirect`. A pop removes the head entry at the clock edge.
- **Space**: space = (`count` − pop + push) < 2. Here push is an accepted ack in the same cycle.
- **Issue**: `req_addr` <= `pc`, `pc` <= `pc`+2, and the FSM enters REQ.
- **IDLE**
  - Without redirect: if space, issue.
  - With redirect: no issue. `pc` <= `redirect_pc`.
- **REQ, `imem_ack`=1, no redirect**
  - Push {`req_addr`, `imem_rdata`}.
  - If space, issue back-to-back and stay in REQ. Otherwise go to IDLE.
- **REQ, `imem_ack`=0, no redirect**: hold `req_addr`. `imem_req` stays high.
- **REQ with redirect**
  - Flush the queue: `count` <= 0.
  - `pc` <= `redirect_pc`.
  - If `imem_ack`=1: discard the data and go to IDLE.
  - If `imem_ack`=0: go to DROP.
- **DROP**
  - Keep `imem_req` and `req_addr` stable until ack.
  - On ack: discard the data and go to IDLE.
  - A redirect in DROP updates `pc` only.
- **Priority**: redirect over push and pop. Pop and push in the same cycle are both applied, and `count` is unchanged.
- **Outstanding requests**: never more than one. Queue overflow is impossible by construction.
- **Wrap-around**: `pc` and `if_pc_plus2` wrap modulo 2^16. 16'hFFFE+2 = 16'h0000.

## Timing
- **Reset values**
  - `imem_req`=0, `imem_addr`=0.
  - `if_valid`=0, `if_instr`=0, `if_pc`=0, `if_pc_plus2`=0, `opcode`=0.
  - `pc`=`RESET_PC`, `count`=0, state IDLE.
- **Reset mid-request**: reset has priority over everything. The outstanding request is abandoned, and an ack arriving later is ignored (state is IDLE).
- **First request**: `imem_req` rises in the first cycle after `reset` deasserts.
- **Latency**: with zero-wait memory (ack in the same cycle as req), a word is visible on `if_*` in the cycle after its ack.
- **Throughput**: steady state is 1 instruction/cycle with zero-wait memory and `stall`=0.
- **Redirect**
  - The queue is empty (`if_valid`=0) in the cycle after a redirect.
  - The first request to `redirect_pc` is issued in the cycle after a redirect from IDLE/REQ, or in the cycle after the dropped ack from DROP.
- **Stall**: with `stall` held, the queue fills to 2 and `imem_req` drops after the second push. No further issue occurs until a pop.

## Test plan
- **Zero-wait streaming**: reset, then release with `RESET_PC`=0, `imem_ack`=`imem_req`, `stall`=0.
  - `imem_addr` 0,2,4,… on consecutive cycles.
  - `if_pc` 0,2,4 from cycle 2 on, with `if_valid` continuously 1.
  - `opcode` = `imem_rdata[15:13]` of each word.
- **Stall fill**: zero-wait memory, `stall`=1 from the first valid word.
  - `count` reaches 2 with entries at 0 and 2. `imem_req`=0.
  - Release `stall`: pops 0 then 2, and the request to 4 re-issues in the release cycle.
- **Redirect with delayed ack**: ack latency 3, `redirect`=1 with `redirect_pc`=16'h0040 one cycle after the request to 4 is issued.
  - Next cycle: `if_valid`=0, state DROP.
  - The word for 4 is discarded on its ack.
  - Next `imem_addr`=16'h0040.
- **Same-cycle events**: `redirect`, `imem_ack`, and a pop in the same cycle, with `redirect_pc`=16'h0101.
  - Queue empty next cycle. The acked word never appears.
  - Next request address is 16'h0100 (bit 0 forced).
- **Wrap**: `RESET_PC`=16'hFFFC, zero-wait memory.
  - `if_pc` = FFFC, FFFE, 0000.
  - `if_pc_plus2` for FFFE is 0000.
- **Reset mid-request**: assert `reset` while in REQ with the ack pending.
  - Next cycle: `imem_req`=0, `if_valid`=0.
  - A late ack is ignored.
  - After release, the first `imem_addr`=`RESET_PC`.
